// File: rtl/dual_issue_fetch_buffer_if.sv
// Bundle of the fetch buffer's instruction-memory port, scheduler issue port
// and redirect inputs.
//   master : the fetch buffer (drives imem request and issue pair)
//   slave  : the environment (memory, scheduler, redirect source)
// Signals:
//   imem_req/imem_addr          fetch request and word-aligned address
//   imem_ready                  memory accepts the request this cycle
//   imem_rvalid/imem_rdata      fetch response
//   freeze1/freeze2             scheduler lane freezes, pop only when both low
//   flush/flush_pc              control-flow redirect and its target
//   instruction0/instruction1   two oldest buffered words (zero when absent)
//   pc0                         PC of instruction0
//   nothing_filled/occupancy    buffer empty flag and entry count
interface dual_issue_fetch_buffer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          freeze1;
    logic          freeze2;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [31:0]   instruction0;
    logic [31:0]   instruction1;
    logic [31:0]   pc0;
    logic          nothing_filled;
    logic [CW-1:0] occupancy;

    modport master (
        output imem_req, imem_addr, instruction0, instruction1, pc0,
               nothing_filled, occupancy,
        input  imem_ready, imem_rvalid, imem_rdata, freeze1, freeze2,
               flush, flush_pc
    );

    modport slave (
        input  imem_req, imem_addr, instruction0, instruction1, pc0,
               nothing_filled, occupancy,
        output imem_ready, imem_rvalid, imem_rdata, freeze1, freeze2,
               flush, flush_pc
    );
endinterface

// File: rtl/dual_issue_fetch_buffer.sv
// Instruction fetch queue feeding the dual-issue scheduler. Fetches 32-bit words
// with at most one request outstanding, buffers them in a circular FIFO and
// presents the two oldest as an issue pair. The pair is popped when neither
// scheduler lane is frozen; a redirect (flush) empties the buffer and discards
// any in-flight fetch.
// Ports:
//   clk    system clock, all state on posedge
//   n_rst  asynchronous active-low reset
//   bus    dual_issue_fetch_buffer_if.master (imem port, issue pair, redirect)
module dual_issue_fetch_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                           clk,
    input  logic                           n_rst,
    dual_issue_fetch_buffer_if.master      bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;

    logic          req;
    logic          accept;
    logic          push;
    logic          pop_en;
    logic [1:0]    popn;
    logic [PW-1:0] head_plus1;

    // Only one request can be outstanding, so checking stored entries alone
    // guarantees the returning word always has a free slot.
    assign req        = (state == StReq) && (count < CW'(DEPTH));
    assign accept     = req && bus.imem_ready;
    assign push       = (state == StWait) && bus.imem_rvalid && !bus.flush;
    assign pop_en     = !bus.freeze1 && !bus.freeze2 && (count != '0);
    assign popn       = !pop_en ? 2'd0 : ((count >= CW'(2)) ? 2'd2 : 2'd1);
    assign head_plus1 = head + PW'(1);

    assign bus.imem_req       = req;
    assign bus.imem_addr      = fetch_pc;
    assign bus.instruction0   = (count != '0)      ? mem[head]       : 32'h0;
    assign bus.instruction1   = (count >= CW'(2))  ? mem[head_plus1] : 32'h0;
    assign bus.pc0            = head_pc;
    assign bus.nothing_filled = (count == '0);
    assign bus.occupancy      = count;

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= StIdle;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
        end else if (bus.flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= bus.flush_pc;
            head_pc  <= bus.flush_pc;
            // Any response still owed by memory must be swallowed in StDrop.
            unique case (state)
                StWait:  state <= bus.imem_rvalid ? StReq : StDrop;
                StReq:   state <= accept ? StDrop : StReq;
                StDrop:  state <= bus.imem_rvalid ? StReq : StDrop;
                default: state <= StReq;
            endcase
        end else begin
            count   <= count + CW'(push) - CW'(popn);
            head    <= head + PW'(popn);
            head_pc <= head_pc + {28'h0, popn, 2'b00};
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            unique case (state)
                StIdle:  state <= StReq;
                StReq:   state <= accept ? StWait : StReq;
                StWait:  state <= bus.imem_rvalid ? StReq : StWait;
                StDrop:  state <= bus.imem_rvalid ? StReq : StDrop;
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Self-checking bench for dual_issue_fetch_buffer. A memory model answers
// accepted fetches after a programmable latency with data derived from the
// address; words the model expects to be kept are queued and compared as the
// scheduler pops them.
module tb_dual_issue_fetch_buffer;
    localparam int unsigned DEPTH = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    dual_issue_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    dual_issue_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    // memory / redirect model state
    bit          pend       = 1'b0;
    bit          pend_stale = 1'b0;
    int          pend_cnt   = 0;
    logic [31:0] pend_addr  = 32'h0;
    logic [31:0] exp_fpc    = 32'h0;
    int          lat        = 1;
    int          budget     = 0;
    bit          do_flush   = 1'b0;
    logic [31:0] fpc_tgt    = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // One clock cycle: drive at negedge, check, then update the model after posedge.
    task automatic tick();
        bit          rv;
        bit          acc;
        bit          pushing;
        int          pn;
        logic [31:0] acc_addr;
        @(negedge clk);
        rv = 1'b0;
        if (pend) begin
            if (pend_cnt <= 1) rv = 1'b1;
            else pend_cnt--;
        end
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? (pend_stale ? 32'hDEAD : data_of(pend_addr)) : 32'h0;
        bus.imem_ready  = (budget > 0);
        bus.flush       = do_flush;
        bus.flush_pc    = fpc_tgt;
        #1;
        check("occupancy", 32'(bus.occupancy), 32'(sb.size()));
        check("nothing_filled", 32'(bus.nothing_filled), 32'(sb.size() == 0));
        if (sb.size() == 0) check("instr0_zero", bus.instruction0, 32'h0);
        if (sb.size() < 2)  check("instr1_zero", bus.instruction1, 32'h0);
        acc      = bus.imem_req && bus.imem_ready;
        acc_addr = exp_fpc;
        if (acc) check("imem_addr", bus.imem_addr, exp_fpc);
        pn = 0;
        if (!bus.freeze1 && !bus.freeze2 && sb.size() > 0 && !do_flush) begin
            check("pop_instr0", bus.instruction0, sb[0].data);
            check("pop_pc0", bus.pc0, sb[0].pc);
            if (sb.size() >= 2) check("pop_instr1", bus.instruction1, sb[1].data);
            pn = (sb.size() >= 2) ? 2 : 1;
        end
        pushing = rv && !pend_stale && !do_flush && n_rst;
        @(posedge clk);
        #1;
        if (do_flush) begin
            sb.delete();
            exp_fpc = fpc_tgt;
        end else begin
            repeat (pn) void'(sb.pop_front());
            if (pushing) sb.push_back('{pend_addr, data_of(pend_addr)});
        end
        if (rv) pend = 1'b0;
        if (do_flush && pend) pend_stale = 1'b1;
        if (acc) begin
            pend       = 1'b1;
            pend_cnt   = lat;
            pend_addr  = acc_addr;
            pend_stale = do_flush;
            budget--;
            if (!do_flush) exp_fpc = exp_fpc + 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(bus.imem_req), 32'h0);
        check({tag, "_occ"}, 32'(bus.occupancy), 32'h0);
        check({tag, "_empty"}, 32'(bus.nothing_filled), 32'h1);
        check({tag, "_i0"}, bus.instruction0, 32'h0);
        check({tag, "_i1"}, bus.instruction1, 32'h0);
        check({tag, "_pc0"}, bus.pc0, 32'h0);
    endtask

    // Asynchronous reset mid-cycle, held for one cycle, then released.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        sb.delete();
        exp_fpc = 32'h0;
        budget  = 0;
        if (pend) pend_stale = 1'b1;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.freeze1     = 1'b1;
        bus.freeze2     = 1'b1;
        bus.flush       = 1'b0;
        bus.flush_pc    = 32'h0;
        #12;
        check_reset_outputs("rst0");
        n_rst = 1'b1;

        // 1: three words with 1-cycle latency, scheduler frozen
        budget = 3;
        lat    = 1;
        for (int i = 0; i < 20 && !(sb.size() == 3 && !pend); i++) tick();
        if (!(sb.size() == 3 && !pend)) check("t1_timeout", 32'h0, 32'h1);
        check("t1_occ", 32'(bus.occupancy), 32'd3);
        check("t1_i0", bus.instruction0, 32'h11);
        check("t1_i1", bus.instruction1, 32'h22);
        check("t1_pc0", bus.pc0, 32'h0);

        // 2: lane-2 freeze alone still blocks, then pop 2, then pop 1
        bus.freeze1 = 1'b0;
        tick();
        check("t2_hold_occ", 32'(bus.occupancy), 32'd3);
        bus.freeze2 = 1'b0;
        tick();
        check("t2_i0", bus.instruction0, 32'h33);
        check("t2_i1", bus.instruction1, 32'h0);
        check("t2_pc0", bus.pc0, 32'h8);
        tick();
        check("t2_empty", 32'(bus.nothing_filled), 32'h1);
        bus.freeze1 = 1'b1;
        bus.freeze2 = 1'b1;

        // 3: fill to DEPTH, request drops, first pop re-raises it
        do_reset("t3rst");
        budget = 100;
        for (int i = 0; i < 60 && !(sb.size() == DEPTH && !pend); i++) tick();
        if (!(sb.size() == DEPTH && !pend)) check("t3_timeout", 32'h0, 32'h1);
        tick();
        check("t3_occ_full", 32'(bus.occupancy), 32'(DEPTH));
        check("t3_req_low", 32'(bus.imem_req), 32'h0);
        budget      = 0;
        bus.freeze1 = 1'b0;
        bus.freeze2 = 1'b0;
        tick();
        bus.freeze1 = 1'b1;
        bus.freeze2 = 1'b1;
        check("t3_req_high", 32'(bus.imem_req), 32'h1);
        check("t3_addr", bus.imem_addr, 32'h20);
        budget = 1;
        for (int i = 0; i < 10 && !(budget == 0 && !pend); i++) tick();

        // 4: flush in WAIT, stale response two cycles later
        lat    = 3;
        budget = 1;
        for (int i = 0; i < 10 && !pend; i++) tick();
        if (!pend) check("t4_timeout", 32'h0, 32'h1);
        do_flush = 1'b1;
        fpc_tgt  = 32'h100;
        tick();
        do_flush = 1'b0;
        for (int i = 0; i < 10 && pend; i++) tick();
        check("t4_occ_after_stale", 32'(bus.occupancy), 32'h0);
        lat    = 1;
        budget = 2;
        for (int i = 0; i < 20 && !(sb.size() == 2 && !pend); i++) tick();
        if (!(sb.size() == 2 && !pend)) check("t4_fill_timeout", 32'h0, 32'h1);
        check("t4_pc0", bus.pc0, 32'h100);
        check("t4_i0", bus.instruction0, 32'h451);
        check("t4_i1", bus.instruction1, 32'h462);

        // 5: flush coincident with rvalid and with a pop
        budget = 1;
        for (int i = 0; i < 10 && !pend; i++) tick();
        if (!pend) check("t5_timeout", 32'h0, 32'h1);
        do_flush    = 1'b1;
        fpc_tgt     = 32'h200;
        bus.freeze1 = 1'b0;
        bus.freeze2 = 1'b0;
        tick();
        do_flush    = 1'b0;
        bus.freeze1 = 1'b1;
        bus.freeze2 = 1'b1;
        check("t5_occ", 32'(bus.occupancy), 32'h0);
        check("t5_pc0", bus.pc0, 32'h200);
        budget = 1;
        for (int i = 0; i < 20 && !(sb.size() == 1 && !pend); i++) tick();
        if (!(sb.size() == 1 && !pend)) check("t5_fill_timeout", 32'h0, 32'h1);
        check("t5_i0", bus.instruction0, 32'h891);

        // 6: reset during WAIT with five entries, late response after release
        budget = 4;
        for (int i = 0; i < 30 && !(sb.size() == 5 && !pend); i++) tick();
        if (!(sb.size() == 5 && !pend)) check("t6_fill_timeout", 32'h0, 32'h1);
        lat    = 4;
        budget = 1;
        for (int i = 0; i < 10 && !pend; i++) tick();
        tick();
        do_reset("t6rst");
        for (int i = 0; i < 6; i++) tick();
        check("t6_occ_late", 32'(bus.occupancy), 32'h0);
        lat    = 1;
        budget = 2;
        for (int i = 0; i < 20 && !(sb.size() == 2 && !pend); i++) tick();
        if (!(sb.size() == 2 && !pend)) check("t6_refill_timeout", 32'h0, 32'h1);
        check("t6_pc0", bus.pc0, 32'h0);
        check("t6_i0", bus.instruction0, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
